// File: rtl/nes_pad_reader.sv
// NES-style serial gamepad poller: latches and clocks the pad, shifts in 8 buttons,
// debounces the one-hot-to-code encoding and presents it as a stable 4-bit level.
module nes_pad_reader #(
  parameter int CLK_DIV        = 300,
  parameter int POLL_INTERVAL  = 833333,
  parameter int DEBOUNCE_POLLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons_raw,
  output logic [3:0] controller_out,
  output logic       sample_valid
);

  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int CW = $clog2(DEBOUNCE_POLLS + 1);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_INTERVAL - 1);
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_POLLS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_HI = 3'd2,
    S_CLK_LO = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    raw_q, raw_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] dbc_q, dbc_d;
  logic          latch_q, latch_d;
  logic          pclk_q, pclk_d;
  logic          valid_q, valid_d;
  logic [3:0]    enc_s;

  // Exactly one button pressed maps to its index+1; none or several map to 0.
  function automatic logic [3:0] encode(input logic [7:0] b);
    logic [3:0] n;
    logic [3:0] code;
    n    = 4'd0;
    code = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        n    = n + 4'd1;
        code = 4'(i + 1);
      end
    end
    return (n == 4'd1) ? code : 4'd0;
  endfunction

  assign enc_s = encode(raw_q);

  // Next-state logic for the frame FSM, poll timer and debouncer.
  always_comb begin
    state_d = state_q;
    poll_d  = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    raw_d   = raw_q;
    ctrl_d  = ctrl_q;
    cand_d  = cand_q;
    dbc_d   = dbc_q;

    case (state_q)
      S_IDLE: begin
        if (poll_q == '0) begin
          state_d = S_LATCH;
          div_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (div_q == LATCH_LAST) begin
          shift_d[0] = ~pad_data;
          bit_d      = 3'd1;
          div_d      = '0;
          state_d    = S_CLK_HI;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_CLK_HI: begin
        if (div_q == HALF_LAST) begin
          div_d   = '0;
          state_d = S_CLK_LO;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_CLK_LO: begin
        if (div_q == HALF_LAST) begin
          shift_d[bit_q] = ~pad_data;
          bit_d          = bit_q + 3'd1;
          div_d          = '0;
          if (bit_q == 3'd7) begin
            // Publish the frame so buttons_raw is valid alongside sample_valid.
            raw_d   = shift_d;
            state_d = S_DONE;
          end else begin
            state_d = S_CLK_HI;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DONE: begin
        if (enc_s == cand_q) begin
          dbc_d = (dbc_q >= DB_MAX) ? DB_MAX : dbc_q + CW'(1);
        end else begin
          cand_d = enc_s;
          dbc_d  = CW'(1);
        end
        if (dbc_d == DB_MAX) begin
          ctrl_d = cand_d;
        end else begin
          ctrl_d = ctrl_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    latch_d = (state_d == S_LATCH);
    pclk_d  = (state_d == S_CLK_HI);
    valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      poll_q  <= '0;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      raw_q   <= 8'd0;
      ctrl_q  <= 4'd0;
      cand_q  <= 4'd0;
      dbc_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      raw_q   <= raw_d;
      ctrl_q  <= ctrl_d;
      cand_q  <= cand_d;
      dbc_q   <= dbc_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      valid_q <= valid_d;
    end
  end

  assign pad_latch      = latch_q;
  assign pad_clk        = pclk_q;
  assign buttons_raw    = raw_q;
  assign controller_out = ctrl_q;
  assign sample_valid   = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: one instance with 2-poll debounce, one with 1-poll,
// each driven by a behavioural NES pad shift-register model.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn;

  logic       pad_data_a, pad_latch_a, pad_clk_a, sv_a;
  logic [7:0] raw_a;
  logic [3:0] ctrl_a;
  logic       pad_data_b, pad_latch_b, pad_clk_b, sv_b;
  logic [7:0] raw_b;
  logic [3:0] ctrl_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(.CLK_DIV(4), .POLL_INTERVAL(100), .DEBOUNCE_POLLS(2)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data_a), .pad_latch(pad_latch_a),
    .pad_clk(pad_clk_a), .buttons_raw(raw_a), .controller_out(ctrl_a), .sample_valid(sv_a)
  );

  nes_pad_reader #(.CLK_DIV(4), .POLL_INTERVAL(100), .DEBOUNCE_POLLS(1)) dut1 (
    .clk(clk), .reset(reset), .pad_data(pad_data_b), .pad_latch(pad_latch_b),
    .pad_clk(pad_clk_b), .buttons_raw(raw_b), .controller_out(ctrl_b), .sample_valid(sv_b)
  );

  // Pad models: latch reloads, each rising pad clock advances to the next button.
  logic [3:0] idx_a = 4'd0, idx_b = 4'd0;
  logic       prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge clk) begin
    if (pad_latch_a) idx_a <= 4'd0;
    else if (pad_clk_a && !prev_a) idx_a <= idx_a + 4'd1;
    prev_a <= pad_clk_a;
    if (pad_latch_b) idx_b <= 4'd0;
    else if (pad_clk_b && !prev_b) idx_b <= idx_b + 4'd1;
    prev_b <= pad_clk_b;
  end

  assign pad_data_a = (idx_a < 4'd8) ? ~btn[idx_a[2:0]] : 1'b1;
  assign pad_data_b = (idx_b < 4'd8) ? ~btn[idx_b[2:0]] : 1'b1;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] raw;
    logic [3:0] ctrl2;
    logic [3:0] ctrl1;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller has just released reset (or the poll timer is at 0): next negedge is frame cycle 0.
  task automatic check_frame(input logic [7:0] exp_raw, input logic [3:0] exp_c2,
                             input logic [3:0] exp_c1);
    logic [2:0] exp_s;
    for (int c = 0; c <= 64; c++) begin
      @(negedge clk);
      exp_s[2] = (c < 8);
      exp_s[1] = (c >= 8) && (c < 64) && (((c - 8) % 8) < 4);
      exp_s[0] = (c == 64);
      chk($sformatf("frame_c%0d_latch_clk_valid", c), {29'd0, pad_latch_a, pad_clk_a, sv_a},
          {29'd0, exp_s});
      if (c == 64) begin
        chk("frame_raw", {24'd0, raw_a}, {24'd0, exp_raw});
        chk("frame_valid_db1", {31'd0, sv_b}, 32'd1);
      end
    end
    @(negedge clk);
    chk("frame_ctrl_db2", {28'd0, ctrl_a}, {28'd0, exp_c2});
    chk("frame_ctrl_db1", {28'd0, ctrl_b}, {28'd0, exp_c1});
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sv_a) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: sample_valid timeout, got 0 expected 1", name);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h40, 8'h40, 4'd7, 4'd7};
    vecs[1]  = '{8'h80, 8'h80, 4'd7, 4'd8};
    vecs[2]  = '{8'h80, 8'h80, 4'd8, 4'd8};
    vecs[3]  = '{8'h00, 8'h00, 4'd8, 4'd0};
    vecs[4]  = '{8'h80, 8'h80, 4'd8, 4'd8};
    vecs[5]  = '{8'h80, 8'h80, 4'd8, 4'd8};
    vecs[6]  = '{8'hC0, 8'hC0, 4'd8, 4'd0};
    vecs[7]  = '{8'hC0, 8'hC0, 4'd0, 4'd0};
    vecs[8]  = '{8'h08, 8'h08, 4'd0, 4'd4};
    vecs[9]  = '{8'h08, 8'h08, 4'd4, 4'd4};
    vecs[10] = '{8'h01, 8'h01, 4'd4, 4'd1};
    vecs[11] = '{8'h01, 8'h01, 4'd1, 4'd1};
    vecs[12] = '{8'h02, 8'h02, 4'd1, 4'd2};
    vecs[13] = '{8'h10, 8'h10, 4'd1, 4'd5};
    vecs[14] = '{8'h10, 8'h10, 4'd5, 4'd5};
    vecs[15] = '{8'h20, 8'h20, 4'd5, 4'd6};
    vecs[16] = '{8'h04, 8'h04, 4'd5, 4'd3};
    vecs[17] = '{8'h04, 8'h04, 4'd3, 4'd3};
    vecs[18] = '{8'h03, 8'h03, 4'd3, 4'd0};

    reset = 1'b1;
    btn   = 8'h00;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {14'd0, pad_latch_a, pad_clk_a, raw_a, ctrl_a, sv_a, 3'd0},
          32'd0);
      chk("reset_outputs_db1", {14'd0, pad_latch_b, pad_clk_b, raw_b, ctrl_b, sv_b, 3'd0},
          32'd0);
    end

    // First poll: LEFT only; debounce-2 must not update yet, debounce-1 must.
    btn   = 8'h40;
    reset = 1'b0;
    check_frame(8'h40, 4'd0, 4'd7);

    for (int v = 0; v < 19; v++) begin
      btn = vecs[v].btn;
      wait_valid($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_raw", v), {24'd0, raw_a}, {24'd0, vecs[v].raw});
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl_db2", v), {28'd0, ctrl_a}, {28'd0, vecs[v].ctrl2});
      chk($sformatf("vec%0d_ctrl_db1", v), {28'd0, ctrl_b}, {28'd0, vecs[v].ctrl1});
    end

    // Abort a frame during CLK_HI of bit 3 (frame cycles 24..27).
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (pad_latch_a) seen = 1'b1;
      end
      chk("abort_latch_seen", {31'd0, seen}, 32'd1);
    end
    repeat (25) @(negedge clk);
    chk("abort_pre_clk_hi", {31'd0, pad_clk_a}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pads", {30'd0, pad_latch_a, pad_clk_a}, 32'd0);
    chk("abort_raw", {24'd0, raw_a}, 32'd0);
    chk("abort_valid", {31'd0, sv_a}, 32'd0);
    chk("abort_ctrl", {28'd0, ctrl_a}, 32'd0);
    @(negedge clk);
    chk("abort_valid_hold", {30'd0, sv_a, sv_b}, 32'd0);

    // Clean frame after release with START: debounce-1 follows on the first DONE.
    btn   = 8'h08;
    reset = 1'b0;
    check_frame(8'h08, 4'd0, 4'd4);
    wait_valid("start_second");
    chk("start_second_raw", {24'd0, raw_a}, 32'h08);
    @(negedge clk);
    chk("start_second_ctrl_db2", {28'd0, ctrl_a}, 32'd4);
    chk("start_second_ctrl_db1", {28'd0, ctrl_b}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
